// File: rtl/peripheral_ahb4_verilog_pkg.sv
// AHB4 master constants, the CPU-to-AHB bridge state type and a byte-enable to HSIZE helper.
package peripheral_ahb4_verilog_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [3:0] HPROT_INSTR = 4'b0010;
    localparam logic [3:0] HPROT_DATA  = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } cpu2ahb_state_t;

    // Unusual byte-enable patterns fall back to a full word access.
    function automatic logic [2:0] be_to_hsize(input logic [7:0] be);
        int unsigned n;
        logic [2:0]  sz;
        n = 0;
        for (int i = 0; i < 8; i++) n += 32'(be[i]);
        if (n == 1)
            sz = HSIZE_BYTE;
        else if (n == 2 && (be & (be >> 1)) != 8'h00)
            sz = HSIZE_HWORD;
        else
            sz = HSIZE_WORD;
        return sz;
    endfunction

endpackage

// File: rtl/soc_riscv_cpu2ahb_arb_sel.sv
// Grant selection between fetch (req0) and data (req1); SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN
// selects round-robin with a last-served pointer, otherwise data has fixed priority.
module soc_riscv_cpu2ahb_arb_sel
    import peripheral_ahb4_verilog_pkg::*;
(
`ifdef SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       take,
`endif
    input  logic       req0,
    input  logic       req1,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic r0, r1;

    assign r0 = req0 & ~mask[0];
    assign r1 = req1 & ~mask[1];

`ifdef SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN
    // last_m1 resets high so the first contended grant goes to m0.
    logic last_m1_q, last_m1_d;

    always_comb begin
        gnt = 2'b00;
        if (r0 && r1)
            gnt = last_m1_q ? 2'b01 : 2'b10;
        else if (r1)
            gnt = 2'b10;
        else if (r0)
            gnt = 2'b01;
    end

    always_comb begin
        last_m1_d = last_m1_q;
        if (take) last_m1_d = gnt[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_m1_q <= 1'b1;
        else     last_m1_q <= last_m1_d;
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (r1)
            gnt = 2'b10;
        else if (r0)
            gnt = 2'b01;
    end
`endif

endmodule

// File: rtl/soc_riscv_cpu2ahb_arbiter.sv
// Two-port CPU (fetch/data) to single AHB4 master bridge, one outstanding transfer.
// Arbitration policy set by SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN (undefined: data wins).
module soc_riscv_cpu2ahb_arbiter
    import peripheral_ahb4_verilog_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PHYS_ADDR_SIZE = XLEN
) (
    input  logic                      HCLK,
    input  logic                      HRESET,

    input  logic                      m0_req,
    input  logic [XLEN-1:0]           m0_adr,
    input  logic                      m0_we,
    input  logic [XLEN/8-1:0]         m0_be,
    input  logic [XLEN-1:0]           m0_d,
    output logic [XLEN-1:0]           m0_q,
    output logic                      m0_ack,
    output logic                      m0_err,

    input  logic                      m1_req,
    input  logic [XLEN-1:0]           m1_adr,
    input  logic                      m1_we,
    input  logic [XLEN/8-1:0]         m1_be,
    input  logic [XLEN-1:0]           m1_d,
    output logic [XLEN-1:0]           m1_q,
    output logic                      m1_ack,
    output logic                      m1_err,

    output logic                      HSEL,
    output logic [PHYS_ADDR_SIZE-1:0] HADDR,
    output logic [XLEN-1:0]           HWDATA,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [3:0]                HPROT,
    output logic [1:0]                HTRANS,
    output logic                      HMASTLOCK,
    input  logic [XLEN-1:0]           HRDATA,
    input  logic                      HREADY,
    input  logic                      HRESP
);

    cpu2ahb_state_t            state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      hsel_q, hsel_d;
    logic [PHYS_ADDR_SIZE-1:0] haddr_q, haddr_d;
    logic [XLEN-1:0]           hwdata_q, hwdata_d;
    logic                      hwrite_q, hwrite_d;
    logic [2:0]                hsize_q, hsize_d;
    logic [2:0]                hburst_q, hburst_d;
    logic [3:0]                hprot_q, hprot_d;
    logic [1:0]                htrans_q, htrans_d;
    logic                      hmastlock_q, hmastlock_d;
    logic                      ack0_q, ack0_d, ack1_q, ack1_d;
    logic                      err0_q, err0_d, err1_q, err1_d;
    logic [XLEN-1:0]           q0_q, q0_d, q1_q, q1_d;

    logic [1:0] gnt;
    logic       ack_pend;
    logic       unused_m0_we;

    assign unused_m0_we = m0_we;

    // The ack cycle is a turnaround: the acked requester still shows its old req, and
    // holding off every grant for that cycle keeps fixed priority strict.
    assign ack_pend = ack0_q | ack1_q;

`ifdef SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN
    logic take;
    assign take = (state_q == ST_IDLE) && (gnt != 2'b00);
`endif

    soc_riscv_cpu2ahb_arb_sel u_sel (
`ifdef SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN
        .clk  (HCLK),
        .rst  (HRESET),
        .take (take),
`endif
        .req0 (m0_req),
        .req1 (m1_req),
        .mask ({2{ack_pend}}),
        .gnt  (gnt)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        hsel_d      = hsel_q;
        haddr_d     = haddr_q;
        hwdata_d    = hwdata_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hburst_d    = hburst_q;
        hprot_d     = hprot_q;
        htrans_d    = htrans_q;
        hmastlock_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        q0_d        = q0_q;
        q1_d        = q1_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    state_d  = ST_ADDR;
                    owner_d  = gnt[1];
                    hsel_d   = 1'b1;
                    htrans_d = HTRANS_NONSEQ;
                    hburst_d = HBURST_SINGLE;
                    if (gnt[1]) begin
                        haddr_d  = m1_adr[PHYS_ADDR_SIZE-1:0];
                        hwdata_d = m1_d;
                        hwrite_d = m1_we;
                        hsize_d  = be_to_hsize(8'(m1_be));
                        hprot_d  = HPROT_DATA;
                    end else begin
                        haddr_d  = m0_adr[PHYS_ADDR_SIZE-1:0];
                        hwdata_d = m0_d;
                        hwrite_d = 1'b0;
                        hsize_d  = be_to_hsize(8'(m0_be));
                        hprot_d  = HPROT_INSTR;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    state_d = ST_IDLE;
                    if (owner_q) begin
                        ack1_d = 1'b1;
                        err1_d = HRESP;
                        q1_d   = HRDATA;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = HRESP;
                        q0_d   = HRDATA;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                hsel_d   = 1'b0;
                htrans_d = HTRANS_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b000;
            hburst_q    <= 3'b000;
            hprot_q     <= 4'b0000;
            htrans_q    <= HTRANS_IDLE;
            hmastlock_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            htrans_q    <= htrans_d;
            hmastlock_q <= hmastlock_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
        end
    end

    assign HSEL      = hsel_q;
    assign HADDR     = haddr_q;
    assign HWDATA    = hwdata_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = hburst_q;
    assign HPROT     = hprot_q;
    assign HTRANS    = htrans_q;
    assign HMASTLOCK = hmastlock_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_err    = err0_q;
    assign m1_err    = err1_q;
    assign m0_q      = q0_q;
    assign m1_q      = q1_q;

endmodule

// File: tb/tb_soc_riscv_cpu2ahb_arbiter.sv
// Directed bench for the CPU-to-AHB arbiter; expectations follow the configured arbitration macro.
module tb_soc_riscv_cpu2ahb_arbiter;

    localparam int XLEN = 32;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic            m0_req, m0_we, m1_req, m1_we;
    logic [XLEN-1:0] m0_adr, m0_d, m1_adr, m1_d, m0_q, m1_q;
    logic [3:0]      m0_be, m1_be;
    logic            m0_ack, m0_err, m1_ack, m1_err;
    logic            HSEL, HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [XLEN-1:0] HADDR, HWDATA, HRDATA;
    logic [2:0]      HSIZE, HBURST;
    logic [3:0]      HPROT;
    logic [1:0]      HTRANS;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    soc_riscv_cpu2ahb_arbiter #(.XLEN(XLEN), .PHYS_ADDR_SIZE(XLEN)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .m0_req(m0_req), .m0_adr(m0_adr), .m0_we(m0_we), .m0_be(m0_be), .m0_d(m0_d),
        .m0_q(m0_q), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_adr(m1_adr), .m1_we(m1_we), .m1_be(m1_be), .m1_d(m1_d),
        .m1_q(m1_q), .m1_ack(m1_ack), .m1_err(m1_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    task automatic tick;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs;
        m0_req = 0; m0_adr = '0; m0_we = 0; m0_be = 4'h0; m0_d = '0;
        m1_req = 0; m1_adr = '0; m1_we = 0; m1_be = 4'h0; m1_d = '0;
        HREADY = 1; HRESP = 0; HRDATA = '0;
    endtask

    task automatic test_reset;
        HRESET = 1;
        idle_inputs();
        m1_req = 1; m1_adr = 32'h40; m1_be = 4'hF;
        repeat (2) tick();
        total++; if (HTRANS !== 2'b00) begin bad++; $display("FAIL reset_htrans got=%0h exp=0", HTRANS); end
        total++; if (HSEL !== 1'b0) begin bad++; $display("FAIL reset_hsel got=%0b exp=0", HSEL); end
        total++; if (HADDR !== 32'h0) begin bad++; $display("FAIL reset_haddr got=%0h exp=0", HADDR); end
        total++; if (HPROT !== 4'h0 || HSIZE !== 3'h0) begin bad++; $display("FAIL reset_hprot_hsize got=%0h/%0h exp=0/0", HPROT, HSIZE); end
        total++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m1_q !== 32'h0) begin bad++; $display("FAIL reset_ack got=%0b%0b q=%0h exp=00 q=0", m0_ack, m1_ack, m1_q); end
        m1_req = 0;
        HRESET = 0;
        tick();
    endtask

    task automatic test_write;
        m1_req = 1; m1_adr = 32'h100; m1_we = 1; m1_be = 4'hF; m1_d = 32'hDEADBEEF; HREADY = 1;
        tick();
        total++; if (HTRANS !== 2'b10 || HSEL !== 1'b1) begin bad++; $display("FAIL wr_addr_phase htrans=%0h hsel=%0b exp=2/1", HTRANS, HSEL); end
        total++; if (HADDR !== 32'h100 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin bad++; $display("FAIL wr_addr_fields haddr=%0h hwrite=%0b hsize=%0d exp=100/1/2", HADDR, HWRITE, HSIZE); end
        total++; if (HPROT !== 4'b0011 || HBURST !== 3'd0 || HMASTLOCK !== 1'b0) begin bad++; $display("FAIL wr_prot hprot=%0h hburst=%0h lock=%0b exp=3/0/0", HPROT, HBURST, HMASTLOCK); end
        tick();
        total++; if (HWDATA !== 32'hDEADBEEF || HTRANS !== 2'b00) begin bad++; $display("FAIL wr_data_phase hwdata=%0h htrans=%0h exp=deadbeef/0", HWDATA, HTRANS); end
        total++; if (m1_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack got=%0b exp=0", m1_ack); end
        tick();
        total++; if (m1_ack !== 1'b1 || m1_err !== 1'b0 || m0_ack !== 1'b0) begin bad++; $display("FAIL wr_ack m1_ack=%0b m1_err=%0b m0_ack=%0b exp=1/0/0", m1_ack, m1_err, m0_ack); end
        m1_req = 0; m1_we = 0;
        tick();
        total++; if (m1_ack !== 1'b0 || HTRANS !== 2'b00) begin bad++; $display("FAIL wr_ack_pulse ack=%0b htrans=%0h exp=0/0", m1_ack, HTRANS); end
    endtask

    task automatic test_wait;
        m0_req = 1; m0_adr = 32'h200; m0_be = 4'hF; m0_we = 1; HREADY = 1;
        tick();
        total++; if (HADDR !== 32'h200 || HPROT !== 4'b0010 || HWRITE !== 1'b0) begin bad++; $display("FAIL rd_addr haddr=%0h hprot=%0h hwrite=%0b exp=200/2/0", HADDR, HPROT, HWRITE); end
        tick();
        HREADY = 0;
        tick();
        total++; if (HTRANS !== 2'b00 || m0_ack !== 1'b0) begin bad++; $display("FAIL rd_wait1 htrans=%0h ack=%0b exp=0/0", HTRANS, m0_ack); end
        tick();
        HREADY = 1; HRDATA = 32'h12345678;
        total++; if (HTRANS !== 2'b00 || m0_ack !== 1'b0) begin bad++; $display("FAIL rd_wait2 htrans=%0h ack=%0b exp=0/0", HTRANS, m0_ack); end
        tick();
        HRDATA = '0;
        total++; if (m0_ack !== 1'b1 || m0_q !== 32'h12345678 || m0_err !== 1'b0) begin bad++; $display("FAIL rd_ack ack=%0b q=%0h err=%0b exp=1/12345678/0", m0_ack, m0_q, m0_err); end
        m0_req = 0; m0_we = 0;
        tick();
    endtask

    task automatic test_err;
        m1_req = 1; m1_adr = 32'h300; m1_be = 4'hF; HREADY = 1; HRESP = 1;
        repeat (3) tick();
        total++; if (m1_ack !== 1'b1 || m1_err !== 1'b1) begin bad++; $display("FAIL err_ack ack=%0b err=%0b exp=1/1", m1_ack, m1_err); end
        m1_req = 0; HRESP = 0;
        tick();
        total++; if (m1_err !== 1'b0 || m1_ack !== 1'b0 || HTRANS !== 2'b00) begin bad++; $display("FAIL err_clear err=%0b ack=%0b htrans=%0h exp=0/0/0", m1_err, m1_ack, HTRANS); end
    endtask

    task automatic test_size;
        m1_req = 1; m1_adr = 32'h2; m1_be = 4'b0011; HREADY = 0;
        tick();
        total++; if (HSIZE !== 3'd1 || HADDR !== 32'h2) begin bad++; $display("FAIL size_half hsize=%0d haddr=%0h exp=1/2", HSIZE, HADDR); end
        tick();
        total++; if (HTRANS !== 2'b10 || HSIZE !== 3'd1 || HADDR !== 32'h2) begin bad++; $display("FAIL addr_hold htrans=%0h hsize=%0d haddr=%0h exp=2/1/2", HTRANS, HSIZE, HADDR); end
        HREADY = 1;
        repeat (2) tick();
        total++; if (m1_ack !== 1'b1) begin bad++; $display("FAIL size_half_ack got=%0b exp=1", m1_ack); end
        m1_req = 0;
        tick();
        m1_req = 1; m1_adr = 32'h6; m1_be = 4'b0100;
        tick();
        total++; if (HSIZE !== 3'd0) begin bad++; $display("FAIL size_byte hsize=%0d exp=0", HSIZE); end
        repeat (2) tick();
        m1_req = 0;
        tick();
    endtask

    task automatic test_reset_mid;
        int acks;
        acks = 0;
        m1_req = 1; m1_adr = 32'h500; m1_be = 4'hF; HREADY = 1;
        repeat (2) tick();
        HRESET = 1;
        #1;
        total++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 32'h0) begin bad++; $display("FAIL rstmid_bus htrans=%0h hsel=%0b haddr=%0h exp=0/0/0", HTRANS, HSEL, HADDR); end
        total++; if (m1_ack !== 1'b0 || m0_ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%0b%0b exp=00", m0_ack, m1_ack); end
        m1_req = 0;
        tick();
        HRESET = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (m1_ack === 1'b1 || m0_ack === 1'b1) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rstmid_no_ack got=%0d acks exp=0", acks); end
    endtask

    task automatic test_arb;
        logic [3:0] seen [3];
        logic [3:0] exp_p [3];
        int n;
`ifdef SOC_RISCV_CPU2AHB_ARB_ROUND_ROBIN_EN
        exp_p = '{4'b0010, 4'b0011, 4'b0010};
`else
        exp_p = '{4'b0011, 4'b0011, 4'b0011};
`endif
        n = 0;
        m0_req = 1; m0_adr = 32'h600; m0_be = 4'hF;
        m1_req = 1; m1_adr = 32'h700; m1_be = 4'hF; m1_we = 0; HREADY = 1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            tick();
            if (HTRANS === 2'b10) begin
                seen[n] = HPROT;
                n++;
            end
        end
        total++; if (n !== 3) begin bad++; $display("FAIL arb_timeout grants=%0d exp=3", n); end
        for (int i = 0; i < 3; i++) begin
            if (i < n) begin
                total++;
                if (seen[i] !== exp_p[i]) begin bad++; $display("FAIL arb_grant%0d hprot=%0h exp=%0h", i, seen[i], exp_p[i]); end
            end
        end
        m0_req = 0; m1_req = 0;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_wait();
        test_err();
        test_size();
        test_reset_mid();
        test_arb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
